// File: rtl/x_rams_clr_if.sv
// Bus bundle for the x_rams_clr LUT-RAM model: address, data, write/reload controls, status.
// With X_RAMS_CLR_PARITY_EN defined it also carries PINJ (parity inject) and PERR (parity error).
interface x_rams_clr_if #(
  parameter int WIDTH      = 1,
  parameter int DEPTH_LOG2 = 7
);
  logic [DEPTH_LOG2-1:0] ADR;
  logic [WIDTH-1:0]      I;
  logic                  WE;
  logic                  CLR;
  logic [WIDTH-1:0]      O;
  logic                  BUSY;
  logic                  DONE;
`ifdef X_RAMS_CLR_PARITY_EN
  logic                  PINJ;
  logic                  PERR;

  modport master (output ADR, I, WE, CLR, PINJ, input O, BUSY, DONE, PERR);
  modport slave  (input ADR, I, WE, CLR, PINJ, output O, BUSY, DONE, PERR);
`else
  modport master (output ADR, I, WE, CLR, input O, BUSY, DONE);
  modport slave  (input ADR, I, WE, CLR, output O, BUSY, DONE);
`endif
endinterface

// File: rtl/x_rams_clr.sv
// Parametrised single-port LUT-RAM with an INIT reload sequencer (BUSY/DONE status).
// Optional per-word even parity with inject/check is enabled by X_RAMS_CLR_PARITY_EN.
module x_rams_clr #(
  parameter int                                 WIDTH      = 1,
  parameter int                                 DEPTH_LOG2 = 7,
  parameter logic [WIDTH*(2**DEPTH_LOG2)-1:0]   INIT       = '0,
  parameter bit                                 OREG       = 1'b0
) (
  input  logic           CLK,
  input  logic           RST_N,
  x_rams_clr_if.slave    bus
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] CNT_LAST = '1;

  typedef enum logic {IDLE, RELOAD} state_t;

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] cnt, cnt_nxt;
  logic                  done, done_nxt;

  // Array content lives outside the reset domain; power-up value is INIT.
  logic [WIDTH*DEPTH-1:0] mem = INIT;
  logic [WIDTH-1:0]       rd_word;
  int                     adr_base;
  int                     cnt_base;

  assign adr_base = int'(bus.ADR) * WIDTH;
  assign cnt_base = int'(cnt) * WIDTH;
  assign rd_word  = mem[adr_base +: WIDTH];

  always_ff @(posedge CLK) begin
    if (state == IDLE && bus.WE)
      mem[adr_base +: WIDTH] <= bus.I;
    else if (state == RELOAD)
      mem[cnt_base +: WIDTH] <= INIT[cnt_base +: WIDTH];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  // Termination is taken from the all-ones count so the last word is written before leaving.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.CLR) begin
          state_nxt = RELOAD;
          cnt_nxt   = '0;
        end
      end
      RELOAD: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.BUSY = (state == RELOAD);
  assign bus.DONE = done;

`ifdef X_RAMS_CLR_PARITY_EN
  function automatic logic [DEPTH-1:0] init_parity();
    logic [DEPTH-1:0] p;
    for (int n = 0; n < DEPTH; n++)
      p[n] = ^INIT[n*WIDTH +: WIDTH];
    return p;
  endfunction

  localparam logic [DEPTH-1:0] INIT_PAR = init_parity();

  logic [DEPTH-1:0] par = INIT_PAR;
  logic             perr_word;

  assign perr_word = (^rd_word) ^ par[bus.ADR];

  always_ff @(posedge CLK) begin
    if (state == IDLE && bus.WE)
      par[bus.ADR] <= (^bus.I) ^ bus.PINJ;
    else if (state == RELOAD)
      par[cnt] <= INIT_PAR[cnt];
  end
`endif

  generate
    if (OREG) begin : g_oreg
      logic [WIDTH-1:0] rd_p1;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rd_p1 <= '0;
        else        rd_p1 <= rd_word;
      end
      assign bus.O = rd_p1;
`ifdef X_RAMS_CLR_PARITY_EN
      logic perr_p1;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) perr_p1 <= 1'b0;
        else        perr_p1 <= perr_word;
      end
      assign bus.PERR = perr_p1;
`endif
    end else begin : g_async
      assign bus.O = rd_word;
`ifdef X_RAMS_CLR_PARITY_EN
      assign bus.PERR = perr_word;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_x_rams_clr.sv
// Self-checking bench for x_rams_clr: one async-read and one registered-read instance share stimulus.
module tb_x_rams_clr;

  localparam int W  = 4;
  localparam int AL = 3;
  localparam int N  = 8;
  localparam logic [31:0] INIT_V = 32'h76543210;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  x_rams_clr_if #(.WIDTH(W), .DEPTH_LOG2(AL)) b0 ();
  x_rams_clr_if #(.WIDTH(W), .DEPTH_LOG2(AL)) b1 ();

  x_rams_clr #(.WIDTH(W), .DEPTH_LOG2(AL), .INIT(INIT_V), .OREG(1'b0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .bus(b0));
  x_rams_clr #(.WIDTH(W), .DEPTH_LOG2(AL), .INIT(INIT_V), .OREG(1'b1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .bus(b1));

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [3:0] mem_m [N];
  logic       par_m [N];
  logic [3:0] oreg_m;
  logic       operr_m;
  bit         busy_m;
  bit         done_m;
  int         pos;

  typedef struct {
    logic [2:0] adr;
    logic [3:0] din;
    logic       we;
    logic [3:0] exp_o0;
    logic [3:0] exp_o1;
  } vec_t;
  vec_t tbl [7];

  function automatic logic [3:0] init_word(input int n);
    return INIT_V[n*4 +: 4];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] a, input logic [3:0] d, input logic we,
                       input logic clr, input logic pinj);
    b0.ADR = a; b0.I = d; b0.WE = we; b0.CLR = clr;
    b1.ADR = a; b1.I = d; b1.WE = we; b1.CLR = clr;
`ifdef X_RAMS_CLR_PARITY_EN
    b0.PINJ = pinj; b1.PINJ = pinj;
`else
    if (pinj === 1'bx) $display("pinj undefined");
`endif
  endtask

  task automatic check_all(input logic [2:0] a);
    chk("o_async", b0.O, mem_m[a]);
    chk("o_reg",   b1.O, oreg_m);
    chk("busy0",   b0.BUSY, busy_m);
    chk("busy1",   b1.BUSY, busy_m);
    chk("done0",   b0.DONE, done_m);
    chk("done1",   b1.DONE, done_m);
`ifdef X_RAMS_CLR_PARITY_EN
    chk("perr_async", b0.PERR, (^mem_m[a]) ^ par_m[a]);
    chk("perr_reg",   b1.PERR, operr_m);
`endif
  endtask

  // One clock: inputs applied at negedge, model stepped at posedge, outputs compared at next negedge.
  task automatic cyc(input logic [2:0] a, input logic [3:0] d, input logic we,
                     input logic clr, input logic pinj);
    drive(a, d, we, clr, pinj);
    @(posedge clk);
    oreg_m  = mem_m[a];
    operr_m = (^mem_m[a]) ^ par_m[a];
    done_m  = 1'b0;
    if (!busy_m) begin
      if (we) begin
        mem_m[a] = d;
        par_m[a] = (^d) ^ pinj;
      end
      if (clr) begin
        busy_m = 1'b1;
        pos    = 0;
      end
    end else begin
      mem_m[pos] = init_word(pos);
      par_m[pos] = ^init_word(pos);
      pos++;
      if (pos == N) begin
        busy_m = 1'b0;
        done_m = 1'b1;
      end
    end
    @(negedge clk);
    check_all(a);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    busy_m = 1'b0; done_m = 1'b0; oreg_m = '0; operr_m = 1'b0;
    chk("rst_busy", b0.BUSY, 1'b0);
    chk("rst_done", b0.DONE, 1'b0);
    chk("rst_oreg", b1.O, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    for (int n = 0; n < N; n++) begin
      mem_m[n] = init_word(n);
      par_m[n] = ^init_word(n);
    end
    oreg_m = '0; operr_m = 1'b0; busy_m = 1'b0; done_m = 1'b0; pos = 0;

    tbl[0] = '{3'd5, 4'h0, 1'b0, 4'h5, 4'h5};
    tbl[1] = '{3'd0, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[2] = '{3'd3, 4'hA, 1'b1, 4'hA, 4'h3};
    tbl[3] = '{3'd2, 4'h0, 1'b0, 4'h2, 4'h2};
    tbl[4] = '{3'd3, 4'h0, 1'b0, 4'hA, 4'hA};
    tbl[5] = '{3'd2, 4'hF, 1'b1, 4'hF, 4'h2};
    tbl[6] = '{3'd2, 4'h0, 1'b0, 4'hF, 4'hF};

    // Power-up under reset
    drive(3'd5, 4'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("pwrup_o5", b0.O, 4'h5);
    chk("pwrup_oreg", b1.O, 4'h0);
    chk("pwrup_busy", b0.BUSY, 1'b0);
    chk("pwrup_done", b0.DONE, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      cyc(tbl[k].adr, tbl[k].din, tbl[k].we, 1'b0, 1'b0);
      chk("tbl_o_async", b0.O, tbl[k].exp_o0);
      chk("tbl_o_reg",   b1.O, tbl[k].exp_o1);
    end

    // Registered output clears asynchronously
    do_reset();

    // Full reload with ignored writes and a second CLR mid-reload
    for (int n = 0; n < N; n++) cyc(3'(n), 4'hF, 1'b1, 1'b0, 1'b0);
    busy_cnt = 0; done_cnt = 0;
    cyc(3'd0, 4'h0, 1'b0, 1'b1, 1'b0);
    busy_cnt += int'(b0.BUSY);
    for (int k = 0; k < N; k++) begin
      cyc(3'((k + 7) % N), 4'h0, 1'b1, (k == 3), 1'b0);
      busy_cnt += int'(b0.BUSY);
      done_cnt += int'(b0.DONE);
    end
    for (int n = 0; n < N; n++) begin
      cyc(3'(n), 4'h0, 1'b0, 1'b0, 1'b0);
      busy_cnt += int'(b0.BUSY);
      done_cnt += int'(b0.DONE);
      chk("reload_rd", b0.O, 32'(n));
    end
    chk("reload_busy_cycles", busy_cnt, 8);
    chk("reload_done_pulses", done_cnt, 1);

    // Reset aborts reload after four words
    for (int n = 0; n < N; n++) cyc(3'(n), 4'hF, 1'b1, 1'b0, 1'b0);
    cyc(3'd0, 4'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc(3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int n = 0; n < N; n++) begin
      cyc(3'(n), 4'h0, 1'b0, 1'b0, 1'b0);
      chk("abort_rd", b0.O, (n < 4) ? 32'(n) : 32'hF);
    end

`ifdef X_RAMS_CLR_PARITY_EN
    cyc(3'd1, 4'hC, 1'b1, 1'b0, 1'b1);
    cyc(3'd2, 4'hC, 1'b1, 1'b0, 1'b0);
    cyc(3'd1, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("perr_inj", b0.PERR, 1'b1);
    cyc(3'd2, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("perr_clean", b0.PERR, 1'b0);
    cyc(3'd0, 4'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < N; k++) cyc(3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < N; n++) begin
      cyc(3'(n), 4'h0, 1'b0, 1'b0, 1'b0);
      chk("perr_reload_async", b0.PERR, 1'b0);
      chk("perr_reload_reg", b1.PERR, 1'b0);
    end
`endif

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      cyc(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/x_rams_clr.md
Name: x_rams_clr

Overview:
- Parametrised single-port distributed RAM, successor to the fixed 128x1 simulation primitive.
- Depth, width and read latency are configurable.
- Adds an on-demand reload sequencer that walks every address and restores the INIT contents, with BUSY/DONE status.
- Sits in the simprims library as the behavioural model for LUT-RAM blocks wider than one bit or deeper than 128.

Parameters:
- WIDTH, 1, data bits per word.
- DEPTH_LOG2, 7, address bits; depth = 2**DEPTH_LOG2.
- INIT, all zeros (WIDTH*2**DEPTH_LOG2 bits), power-up and reload contents; word n = INIT[n*WIDTH +: WIDTH].
- OREG, 0, 0 = asynchronous read; 1 = registered read, 1-cycle latency.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- ADR  input  DEPTH_LOG2  read/write address.
- I  input  WIDTH  write data.
- WE  input  1  write enable.
- CLR  input  1  reload request, sampled on CLK.
- O  output  WIDTH  read data.
- BUSY  output  1  reload in progress.
- DONE  output  1  one-cycle pulse at reload completion.

Behaviour:
- Interface: one clock CLK; RST_N is asynchronous, active-low.
- Memory array is never touched by reset. At time zero it holds INIT.
- RST_N low, immediately:
  - FSM goes to IDLE, reload counter = 0.
  - BUSY = 0, DONE = 0.
  - O register = 0 when OREG=1.
- User write: at posedge CLK, if WE=1 and FSM is IDLE, mem[ADR] <= I. WE is ignored while BUSY=1.
- Read, OREG=0: O = mem[ADR] combinationally. After a write edge, O shows the new data in the same cycle.
- Read, OREG=1: O <= mem[ADR] at every posedge (read-first). On a same-address write, O shows the old word for one cycle and the new word on the next edge.
- Reads stay live during reload and return whatever is currently stored.
- FSM states:
  - IDLE: CLR=1 at posedge -> RELOAD, counter = 0, BUSY = 1 from that edge.
  - RELOAD: each posedge writes INIT word[counter] into mem[counter] and increments the counter. When counter = 2**DEPTH_LOG2-1, that write completes -> IDLE, BUSY = 0, DONE = 1 for exactly one cycle.
- Reload takes exactly 2**DEPTH_LOG2 cycles with BUSY=1.
- CLR while in RELOAD is ignored; no restart or extension.
- CLR and WE in the same IDLE cycle: the user write is performed at that edge and the reload starts; the reload later overwrites that word.
- Counter is DEPTH_LOG2 bits wide. Termination is detected on the all-ones value, not on wrap.
- Reset mid-reload: aborts at once. Words already written keep INIT values, the remaining words keep prior contents, and no DONE pulse is generated.
- DONE is registered and deasserts on the following edge regardless of CLR.

Optional Feature:
- Macro X_RAMS_CLR_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit computed from I on write.
  - New input PINJ (1 bit): when PINJ=1 together with a write, the stored parity is inverted.
  - Reload stores correct parity for INIT words.
  - New output PERR (1 bit) = parity mismatch of the word being read. It follows O timing: combinational when OREG=0, registered when OREG=1, reset to 0.
- Undefined: no parity storage, no PINJ or PERR ports; behaviour otherwise identical.

Test Plan:
- Power-up, WIDTH=4, DEPTH_LOG2=3, INIT=32'h76543210, OREG=0 -> ADR=5 gives O=4'h5; ADR=0 gives O=4'h0.
- OREG=0, write I=4'hA at ADR=3 -> O=4'hA in the same cycle after the edge; address 2 still reads 4'h2.
- OREG=1, ADR=2 holding 4'h2, WE=1, I=4'hF -> O=4'h2 after edge 1, O=4'hF after edge 2; RST_N low forces O=0 asynchronously.
- Fill all 8 words with 4'hF, pulse CLR for one cycle:
  - BUSY=1 for 8 cycles; WE=1 with I=4'h0 during reload is ignored.
  - DONE pulses once.
  - Readback of address n gives n; a second CLR mid-reload does not extend BUSY.
- Fill all words with 4'hF, start reload, drop RST_N after 4 reload writes -> BUSY=0 and DONE=0 immediately; addresses 0-3 read 0-3, addresses 4-7 read 4'hF.
- Macro defined, write 4'hC at ADR=1 with PINJ=1 and 4'hC at ADR=2 with PINJ=0 -> reading ADR=1 gives PERR=1, ADR=2 gives PERR=0; after reload, PERR=0 at every address.
